rxd_command_receiver: RTL and testbench

//  UART receiver for the USB-RS232 link (host -> FPGA); receive-side counterpart of TxDWrapper.

---
 rtl/rxd_command_receiver_pkg.sv | 23 ++
 rtl/rxd_command_receiver_if.sv | 20 ++
 rtl/rxd_command_receiver_sample_tick.sv | 40 ++++
 rtl/rxd_command_receiver.sv | 185 ++++++++++++++++++
 tb/tb_rxd_command_receiver.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rxd_command_receiver_pkg.sv
// Shared constants for the RS232 command receiver: FSM encoding, frame width,
// sample-rate arithmetic and the three-sample majority vote.
package rxd_command_receiver_pkg;

  localparam int DATA_BITS = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  function automatic int clksPerSample(input int clkFreq, input int baudRate,
                                       input int overSample);
    return clkFreq / (baudRate * overSample);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rxd_command_receiver_if.sv
// Holding-register side of the receiver: byte, valid/read handshake, error pulses.
interface rxd_command_receiver_if;
  logic [7:0] DataOut;
  logic       DataValid;
  logic       DataRead;
  logic       FrameError;
  logic       Overrun;
  logic       ParityError;
  logic       Busy;

  modport master (
    output DataOut, DataValid, FrameError, Overrun, ParityError, Busy,
    input  DataRead
  );

  modport slave (
    input  DataOut, DataValid, FrameError, Overrun, ParityError, Busy,
    output DataRead
  );
endinterface

// File: rtl/rxd_command_receiver_sample_tick.sv
// Oversampling divider: one tick every CLKS_PER_SAMPLE clocks plus the index of
// that sample within the current bit; restart realigns both to a start edge.
module rxd_command_receiver_sample_tick #(
  parameter int CLKS_PER_SAMPLE = 10,
  parameter int OVERSAMPLE      = 10
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          restart,
  output logic                          tick,
  output logic [$clog2(OVERSAMPLE)-1:0] sampleIdx
);

  localparam int CNT_W = $clog2(CLKS_PER_SAMPLE);
  localparam int IDX_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_SAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] clkCnt;

  assign tick = (clkCnt == '0);

  // The restart cycle itself stands in for sample 0, so the first tick after it
  // carries index 1 and index i lands exactly i sample periods after the edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      clkCnt    <= '0;
      sampleIdx <= '0;
    end else if (restart) begin
      clkCnt    <= CNT_LOAD;
      sampleIdx <= IDX_W'(1);
    end else if (tick) begin
      clkCnt    <= CNT_LOAD;
      sampleIdx <= (sampleIdx == IDX_LAST) ? '0 : sampleIdx + 1'b1;
    end else begin
      clkCnt    <= clkCnt - 1'b1;
    end
  end

endmodule

// File: rtl/rxd_command_receiver.sv
// Host->FPGA UART receiver with majority-voted bits and a one-byte holding register.
// Define RX_PARITY_EN for 8E1 frames with ParityError; default build is 8N1.
//
// state      | meaning
// IDLE       | line idle, waiting for synced SDI=0
// START      | checking start bit at mid-bit (glitch reject)
// DATA       | shifting in 8 data bits, LSB first
// PARITY     | sampling even-parity bit (RX_PARITY_EN only)
// STOP       | checking stop bit; good -> commit, bad -> FrameError
// WAIT_IDLE  | after a framing error, wait for line to return high
module rxd_command_receiver
  import rxd_command_receiver_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 1_000_000,
  parameter int OVERSAMPLE = 10
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          SDI,
  rxd_command_receiver_if.master        rxIf
);

  localparam int CLKS_PER_SAMPLE = clksPerSample(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int IDX_W = $clog2(OVERSAMPLE);
  localparam logic [IDX_W-1:0] IDX_A    = IDX_W'(OVERSAMPLE / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_B    = IDX_W'(OVERSAMPLE / 2);
  localparam logic [IDX_W-1:0] IDX_VOTE = IDX_W'(OVERSAMPLE / 2 + 1);

`ifdef RX_PARITY_EN
  localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
  localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

  logic                 sdiMeta, sdiSync;
  logic [2:0]           state;
  logic                 restart, tick, atVote, vote;
  logic [IDX_W-1:0]     sampleIdx;
  logic                 sampA, sampB;
  logic [2:0]           bitCnt;
  logic [DATA_BITS-1:0] shiftReg;
  logic                 commitPend, commitOk, parityBad;
  logic                 frameErr, overrun, dataValid;
  logic [DATA_BITS-1:0] dataOut;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sdiMeta <= 1'b1;
      sdiSync <= 1'b1;
    end else begin
      sdiMeta <= SDI;
      sdiSync <= sdiMeta;
    end
  end

  assign restart = (state == ST_IDLE) && !sdiSync;

  rxd_command_receiver_sample_tick #(
    .CLKS_PER_SAMPLE (CLKS_PER_SAMPLE),
    .OVERSAMPLE      (OVERSAMPLE)
  ) u_tick (
    .Clock     (Clock),
    .Reset     (Reset),
    .restart   (restart),
    .tick      (tick),
    .sampleIdx (sampleIdx)
  );

  // The third vote sample is the live synced value, so the decision is taken
  // on the tick of the last sample rather than one cycle later.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sampA <= 1'b1;
      sampB <= 1'b1;
    end else if (tick) begin
      if (sampleIdx == IDX_A) sampA <= sdiSync;
      if (sampleIdx == IDX_B) sampB <= sdiSync;
    end
  end

  assign atVote = tick && (sampleIdx == IDX_VOTE);
  assign vote   = majority3(sampA, sampB, sdiSync);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= ST_IDLE;
      bitCnt     <= '0;
      shiftReg   <= '0;
      commitPend <= 1'b0;
      frameErr   <= 1'b0;
`ifdef RX_PARITY_EN
      parityBad  <= 1'b0;
`endif
    end else begin
      commitPend <= 1'b0;
      frameErr   <= 1'b0;
      case (state)
        ST_IDLE:
          if (restart) state <= ST_START;
        ST_START:
          if (atVote) begin
            if (vote) begin
              state <= ST_IDLE;
            end else begin
              state  <= ST_DATA;
              bitCnt <= 3'(DATA_BITS - 1);
            end
          end
        ST_DATA:
          if (atVote) begin
            shiftReg <= {vote, shiftReg[DATA_BITS-1:1]};
            if (bitCnt == '0) state  <= ST_AFTER_DATA;
            else              bitCnt <= bitCnt - 1'b1;
          end
`ifdef RX_PARITY_EN
        ST_PARITY:
          if (atVote) begin
            parityBad <= ^{shiftReg, vote};
            state     <= ST_STOP;
          end
`endif
        ST_STOP:
          if (atVote) begin
            if (vote) begin
              commitPend <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              frameErr <= 1'b1;
              state    <= ST_WAIT_IDLE;
            end
          end
        ST_WAIT_IDLE:
          if (sdiSync) state <= ST_IDLE;
        default:
          state <= ST_IDLE;
      endcase
    end
  end

`ifndef RX_PARITY_EN
  assign parityBad = 1'b0;
`endif

  assign commitOk = commitPend && !parityBad;

  // A read in the commit cycle frees the register for the incoming byte.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      dataOut   <= '0;
      dataValid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commitOk && (!dataValid || rxIf.DataRead)) begin
        dataOut   <= shiftReg;
        dataValid <= 1'b1;
      end else if (commitOk) begin
        overrun <= 1'b1;
      end else if (rxIf.DataRead) begin
        dataValid <= 1'b0;
      end
    end
  end

`ifdef RX_PARITY_EN
  logic parityErr;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) parityErr <= 1'b0;
    else        parityErr <= commitPend && parityBad;
  end

  assign rxIf.ParityError = parityErr;
`else
  assign rxIf.ParityError = 1'b0;
`endif

  assign rxIf.DataOut    = dataOut;
  assign rxIf.DataValid  = dataValid;
  assign rxIf.FrameError = frameErr;
  assign rxIf.Overrun    = overrun;
  assign rxIf.Busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_rxd_command_receiver.sv
// Scoreboard bench for rxd_command_receiver: directed frames push expected events,
// a negedge monitor pops and compares every byte/error the receiver presents.
`timescale 1ns/1ps
module tb_rxd_command_receiver;

  localparam int CLK_FREQ   = 100_000_000;
  localparam int BAUD_RATE  = 5_000_000;
  localparam int OVERSAMPLE = 10;
  localparam int CPS        = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int BIT_CLKS   = CPS * OVERSAMPLE;
`ifdef RX_PARITY_EN
  localparam bit PARITY_ON  = 1'b1;
`else
  localparam bit PARITY_ON  = 1'b0;
`endif
  localparam int FRAME_BITS = PARITY_ON ? 11 : 10;
  // posedges from the edge launching a start bit to the start of its commit cycle:
  // 2 sync + 1 restart, then the stop-bit vote sample, then one cycle to register it
  localparam int COMMIT_OFS = 3 + ((FRAME_BITS - 1) * OVERSAMPLE + OVERSAMPLE / 2 + 1) * CPS;

  typedef enum int {EV_BYTE, EV_FRAME, EV_OVERRUN, EV_PARITY} evKind_t;
  typedef struct {
    evKind_t    kind;
    logic [7:0] data;
  } ev_t;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic SDI   = 1'b1;
  logic manualRead = 1'b0;
  logic autoRead   = 1'b0;

  ev_t  expQ[$];
  int   nCompared   = 0;
  int   nMismatched = 0;
  logic       prevValid = 1'b0;
  logic [7:0] prevOut   = 8'h00;

  rxd_command_receiver_if rxIf ();

  assign rxIf.DataRead = manualRead | (autoRead & rxIf.DataValid);

  rxd_command_receiver #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .SDI   (SDI),
    .rxIf  (rxIf)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushExp(input evKind_t kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    expQ.push_back(e);
  endtask

  task automatic observe(input evKind_t kind, input logic [7:0] data);
    ev_t e;
    if (expQ.size() == 0) begin
      nCompared++;
      nMismatched++;
      $display("FAIL unexpected event: got kind %0d data 0x%02h, expected nothing", kind, data);
    end else begin
      e = expQ.pop_front();
      check("event kind", 32'(kind), 32'(e.kind));
      if (kind == EV_BYTE && e.kind == EV_BYTE) check("byte value", 32'(data), 32'(e.data));
    end
  endtask

  always @(negedge Clock) begin
    if (Reset) begin
      if (rxIf.FrameError)  observe(EV_FRAME, 8'h00);
      if (rxIf.ParityError) observe(EV_PARITY, 8'h00);
      if (rxIf.Overrun)     observe(EV_OVERRUN, 8'h00);
      if (rxIf.DataValid && (!prevValid || rxIf.DataOut != prevOut))
        observe(EV_BYTE, rxIf.DataOut);
    end
    prevValid = rxIf.DataValid;
    prevOut   = rxIf.DataOut;
  end

  // All driver tasks start and end 1 ns after a rising edge.
  task automatic sendBit(input logic b);
    SDI = b;
    repeat (BIT_CLKS) @(posedge Clock);
    #1;
  endtask

  task automatic sendIdle(input int nBits);
    repeat (nBits) sendBit(1'b1);
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic stopBit, input logic parBit);
    logic [10:0] f;
    f = {stopBit, parBit, d, 1'b0};
    for (int i = 0; i < 11; i++)
      if (i != 9 || PARITY_ON) sendBit(f[i]);
  endtask

  task automatic sendByte(input logic [7:0] d);
    sendFrame(d, 1'b1, ^d);
  endtask

  task automatic readPulse();
    manualRead = 1'b1;
    @(posedge Clock);
    #1;
    manualRead = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    check({tag, " DataOut"},     32'(rxIf.DataOut),     32'h00);
    check({tag, " DataValid"},   32'(rxIf.DataValid),   32'd0);
    check({tag, " Busy"},        32'(rxIf.Busy),        32'd0);
    check({tag, " FrameError"},  32'(rxIf.FrameError),  32'd0);
    check({tag, " Overrun"},     32'(rxIf.Overrun),     32'd0);
    check({tag, " ParityError"}, 32'(rxIf.ParityError), 32'd0);
  endtask

  task automatic checkDrained(input string tag);
    check({tag, " pending events"}, 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 Reset = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    checkResetState("reset");
    Reset = 1'b1;
    sendIdle(2);

    // 1: plain byte, held until read
    pushExp(EV_BYTE, 8'h55);
    sendByte(8'h55);
    sendIdle(3);
    check("t1 DataValid held", 32'(rxIf.DataValid), 32'd1);
    check("t1 DataOut", 32'(rxIf.DataOut), 32'h55);
    readPulse();
    check("t1 DataValid after read", 32'(rxIf.DataValid), 32'd0);
    checkDrained("t1");

    // 2: short low glitch is rejected silently
    SDI = 1'b0;
    repeat (3 * CPS) @(posedge Clock);
    #1;
    SDI = 1'b1;
    check("t2 Busy during glitch", 32'(rxIf.Busy), 32'd1);
    sendIdle(2);
    check("t2 Busy after glitch", 32'(rxIf.Busy), 32'd0);
    check("t2 DataValid", 32'(rxIf.DataValid), 32'd0);
    checkDrained("t2");

    // 3: bad stop bit followed by a long break, then a good byte
    pushExp(EV_FRAME, 8'h00);
    sendFrame(8'hA3, 1'b0, ^8'hA3);
    repeat (20) sendBit(1'b0);
    sendIdle(2);
    check("t3 DataValid after break", 32'(rxIf.DataValid), 32'd0);
    checkDrained("t3 break");
    pushExp(EV_BYTE, 8'h3C);
    sendByte(8'h3C);
    sendIdle(2);
    check("t3 DataOut", 32'(rxIf.DataOut), 32'h3C);
    readPulse();
    checkDrained("t3");

    // 4a: back-to-back with no read -> overrun, first byte kept
    pushExp(EV_BYTE, 8'h12);
    pushExp(EV_OVERRUN, 8'h00);
    sendByte(8'h12);
    sendByte(8'h34);
    sendIdle(2);
    check("t4a DataOut kept", 32'(rxIf.DataOut), 32'h12);
    check("t4a DataValid", 32'(rxIf.DataValid), 32'd1);
    readPulse();
    check("t4a DataValid after read", 32'(rxIf.DataValid), 32'd0);
    checkDrained("t4a");

    // 4b: read lands on the second commit cycle -> new byte, no overrun
    pushExp(EV_BYTE, 8'h12);
    pushExp(EV_BYTE, 8'h34);
    fork
      begin
        sendByte(8'h12);
        sendByte(8'h34);
        sendIdle(2);
      end
      begin
        repeat (FRAME_BITS * BIT_CLKS + COMMIT_OFS) @(posedge Clock);
        #1;
        readPulse();
      end
    join
    check("t4b DataOut", 32'(rxIf.DataOut), 32'h34);
    check("t4b DataValid", 32'(rxIf.DataValid), 32'd1);
    readPulse();
    checkDrained("t4b");

`ifdef RX_PARITY_EN
    // 5: wrong then right parity
    pushExp(EV_PARITY, 8'h00);
    sendFrame(8'h07, 1'b1, 1'b0);
    sendIdle(2);
    check("t5 DataValid after bad parity", 32'(rxIf.DataValid), 32'd0);
    pushExp(EV_BYTE, 8'h07);
    sendFrame(8'h07, 1'b1, 1'b1);
    sendIdle(2);
    check("t5 DataOut", 32'(rxIf.DataOut), 32'h07);
    readPulse();
    checkDrained("t5");
`endif

    // 6: reset in the middle of a frame while a byte is waiting
    pushExp(EV_BYTE, 8'h5A);
    sendByte(8'h5A);
    sendIdle(2);
    check("t6 DataValid before reset", 32'(rxIf.DataValid), 32'd1);
    fork
      sendByte(8'hF0);
      begin
        repeat (5 * BIT_CLKS + BIT_CLKS / 2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        #1;
        checkResetState("t6 in reset");
      end
    join
    Reset = 1'b1;
    sendIdle(2);
    checkResetState("t6 after reset");
    pushExp(EV_BYTE, 8'h81);
    sendByte(8'h81);
    sendIdle(2);
    check("t6 DataOut", 32'(rxIf.DataOut), 32'h81);
    readPulse();
    checkDrained("t6");

    // loopback sweep of every byte value, back-to-back frames
    autoRead = 1'b1;
    for (int b = 0; b < 256; b++) begin
      pushExp(EV_BYTE, 8'(b));
      sendByte(8'(b));
    end
    sendIdle(2);
    autoRead = 1'b0;
    check("sweep DataValid", 32'(rxIf.DataValid), 32'd0);
    checkDrained("sweep");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
